// File: rtl/color_mapping_mul_arb_pkg.sv
// ============================================================================
// Module   : color_mapping_mul_arb_pkg
// Purpose  : Shared types, defaults and helpers for the color-mapping
//            multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package color_mapping_mul_arb_pkg;

    localparam int A_W_DEF = 18;
    localparam int B_W_DEF = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    // Round-robin successor with wrap for non-power-of-two requester counts.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/color_mapping_rr_pick.sv
// ============================================================================
// Module   : color_mapping_rr_pick
// Purpose  : Combinational rotate-priority encoder; first request at or
//            above the pointer (with wrap) wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_mapping_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Scan from farthest to nearest so the nearest match is the last write.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/color_mapping_mul_arbiter.sv
// ============================================================================
// Module   : color_mapping_mul_arbiter
// Purpose  : Round-robin time-sharing of one unsigned multiplier between
//            NUM_REQ requesters, with enable/drain FSM. Optional macro
//            COLOR_MAPPING_MUL_ARB_PIPE2_EN adds a second product stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_mapping_mul_arbiter
    import color_mapping_mul_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int A_W     = A_W_DEF,
    parameter  int B_W     = B_W_DEF,
    parameter  int ID_W    = $clog2(NUM_REQ),
    localparam int P_W     = A_W + B_W
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   cfg_en,
    output logic                   busy,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [P_W-1:0]         res_product
);

    fsm_t               state_q;
    logic               busy_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic               res_valid_q;
    logic [ID_W-1:0]    res_id_q;
    logic [P_W-1:0]     res_prod_q;

    logic               adv;
    logic               drain_done;
    logic               grant_en;
    logic               xfer;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [A_W-1:0]     a_sel;
    logic [B_W-1:0]     b_sel;
    logic [P_W-1:0]     prod;

    color_mapping_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign grant_en  = (state_q == RUN) && adv;
    assign req_ready = grant_en ? pick_gnt : '0;
    assign xfer      = grant_en && pick_any;

    assign a_sel = req_a[int'(pick_idx)*A_W +: A_W];
    assign b_sel = req_b[int'(pick_idx)*B_W +: B_W];
    assign prod  = P_W'(a_sel) * P_W'(b_sel);
    assign ptr_d = xfer ? ID_W'(rr_next(32'(pick_idx), NUM_REQ)) : ptr_q;

`ifdef COLOR_MAPPING_MUL_ARB_PIPE2_EN
    logic            s1_valid_q;
    logic [ID_W-1:0] s1_id_q;
    logic [P_W-1:0]  s1_prod_q;
    logic            adv_out;

    // Elastic two-stage pipe: each stage moves when empty or when downstream moves.
    assign adv_out    = !res_valid_q || res_ready;
    assign adv        = !s1_valid_q || adv_out;
    assign drain_done = !s1_valid_q && adv_out;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_prod_q   <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_prod_q  <= '0;
        end else begin
            if (adv) begin
                s1_valid_q <= xfer;
                if (xfer) begin
                    s1_id_q   <= pick_idx;
                    s1_prod_q <= prod;
                end
            end
            if (adv_out) begin
                res_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_id_q   <= s1_id_q;
                    res_prod_q <= s1_prod_q;
                end
            end
        end
    end
`else
    assign adv        = !res_valid_q || res_ready;
    assign drain_done = adv;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_prod_q  <= '0;
        end else if (xfer) begin
            res_valid_q <= 1'b1;
            res_id_q    <= pick_idx;
            res_prod_q  <= prod;
        end else if (res_ready) begin
            res_valid_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // busy is registered alongside the state so it equals (state != IDLE).
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_en) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!cfg_en) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cfg_en) begin
                        state_q <= RUN;
                    end else if (drain_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign res_product = res_prod_q;

endmodule

`default_nettype wire

// File: tb/tb_color_mapping_mul_arbiter.sv
// ============================================================================
// Module   : tb_color_mapping_mul_arbiter
// Purpose  : Self-checking bench for color_mapping_mul_arbiter (default
//            single-stage build) against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_color_mapping_mul_arbiter;

    localparam int N  = 4;
    localparam int AW = 18;
    localparam int BW = 18;
    localparam int PW = 36;
    localparam int IW = 2;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic            cfg_en;
    logic            busy;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            res_valid;
    logic            res_ready;
    logic [IW-1:0]   res_id;
    logic [PW-1:0]   res_product;

    logic [AW-1:0]   a_arr [N];
    logic [BW-1:0]   b_arr [N];

    int total = 0;
    int bad   = 0;

    // Reference model: state 0=idle 1=run 2=drain
    int          m_state;
    int          m_ptr;
    int          m_id;
    bit          m_valid;
    logic [PW-1:0] m_prod;

    always #5 ap_clk = ~ap_clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = a_arr[i];
            req_b[i*BW +: BW] = b_arr[i];
        end
    end

    color_mapping_mul_arbiter #(.NUM_REQ(N)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .cfg_en      (cfg_en),
        .busy        (busy),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_product (res_product)
    );

    function automatic int model_pick();
        if (m_state != 1) return -1;
        if (m_valid && !res_ready) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_pick();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic load_req(input int i);
        int sel;
        req_valid[i] = 1'b1;
        sel = $urandom_range(0, 7);
        a_arr[i] = (sel == 0) ? '0 : (sel == 1) ? '1 : AW'($urandom);
        sel = $urandom_range(0, 7);
        b_arr[i] = (sel == 0) ? '0 : (sel == 1) ? '1 : BW'($urandom);
    endtask

    // One clock: model computes its next state from current inputs, then
    // the granted requester is cleared (mode 1) or reloaded (mode 2).
    task automatic advance(input int mode);
        int g;
        int ns;
        g  = model_pick();
        ns = m_state;
        case (m_state)
            0:       if (cfg_en) ns = 1;
            1:       if (!cfg_en) ns = 2;
            default: if (cfg_en) ns = 1; else if (!m_valid || res_ready) ns = 0;
        endcase
        @(posedge ap_clk);
        #1;
        if (ap_rst) begin
            m_state = 0; m_ptr = 0; m_valid = 0; m_id = 0; m_prod = '0;
            g = -1;
        end else begin
            if (g >= 0) begin
                m_valid = 1;
                m_id    = g;
                m_prod  = {18'b0, a_arr[g]} * {18'b0, b_arr[g]};
                m_ptr   = (g + 1) % N;
            end else if (res_ready) begin
                m_valid = 0;
            end
            m_state = ns;
        end
        if (g >= 0) begin
            if (mode == 1) req_valid[g] = 1'b0;
            else if (mode == 2) load_req(g);
        end
    endtask

    task automatic do_reset();
        ap_rst    = 1'b1;
        cfg_en    = 1'b0;
        res_ready = 1'b0;
        req_valid = '0;
        advance(0);
        advance(0);
        ap_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", res_valid); end
        total++; if (res_id !== '0) begin bad++; $display("FAIL reset_id: got %0d expected 0", res_id); end
        total++; if (res_product !== '0) begin bad++; $display("FAIL reset_product: got %0h expected 0", res_product); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        req_valid = '1;
        #1;
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        cfg_en = 1'b1;
        res_ready = 1'b1;
        advance(0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b expected 1", busy); end
        req_valid[0] = 1'b1; a_arr[0] = 18'd3; b_arr[0] = 18'd5;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        advance(1);
        total++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_product !== 36'd15) begin
            bad++; $display("FAIL single_result: got v=%0b id=%0d p=%0d expected v=1 id=0 p=15", res_valid, res_id, res_product);
        end
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_drop: got %b expected 0000", req_ready); end
        advance(0);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_consumed: got %0b expected 0", res_valid); end
    endtask

    task automatic test_round_robin();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        cfg_en = 1'b1;
        res_ready = 1'b1;
        advance(0);
        for (int i = 0; i < N; i++) load_req(i);
        for (int k = 0; k < 6; k++) begin
            advance(2);
            total++; if (res_valid !== 1'b1 || res_id !== IW'(exp_seq[k]) || res_product !== m_prod) begin
                bad++; $display("FAIL rr_seq%0d: got v=%0b id=%0d p=%0h expected v=1 id=%0d p=%0h",
                                k, res_valid, res_id, res_product, exp_seq[k], m_prod);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] hold_prod;
        req_valid = '0;
        advance(0);
        advance(0);
        load_req(2);
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_first_ready: got %b expected 0100", req_ready); end
        advance(1);
        hold_prod = m_prod;
        total++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_product !== hold_prod) begin
            bad++; $display("FAIL bp_first: got v=%0b id=%0d p=%0h expected v=1 id=2 p=%0h", res_valid, res_id, res_product, hold_prod);
        end
        res_ready = 1'b0;
        load_req(2);
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready%0d: got %b expected 0000", k, req_ready); end
            advance(0);
            total++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_product !== hold_prod) begin
                bad++; $display("FAIL bp_hold%0d: got v=%0b id=%0d p=%0h expected v=1 id=2 p=%0h", k, res_valid, res_id, res_product, hold_prod);
            end
        end
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_resume_ready%0d: got %b expected 0100", k, req_ready); end
            advance(2);
            total++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_product !== m_prod) begin
                bad++; $display("FAIL bp_resume%0d: got v=%0b id=%0d p=%0h expected v=1 id=2 p=%0h", k, res_valid, res_id, res_product, m_prod);
            end
        end
        req_valid = '0;
        advance(0);
    endtask

    task automatic test_boundary();
        req_valid[1] = 1'b1; a_arr[1] = 18'h3FFFF; b_arr[1] = 18'h3FFFF;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bnd_ready: got %b expected 0010", req_ready); end
        advance(1);
        total++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_product !== 36'hF_FFF8_0001) begin
            bad++; $display("FAIL bnd_max: got v=%0b id=%0d p=%0h expected v=1 id=1 p=ffff80001", res_valid, res_id, res_product);
        end
        req_valid[1] = 1'b1; a_arr[1] = 18'h0; b_arr[1] = 18'h3FFFF;
        advance(1);
        total++; if (res_valid !== 1'b1 || res_product !== 36'h0) begin
            bad++; $display("FAIL bnd_zero: got v=%0b p=%0h expected v=1 p=0", res_valid, res_product);
        end
        advance(0);
    endtask

    task automatic test_drain();
        res_ready = 1'b0;
        req_valid[0] = 1'b1; a_arr[0] = 18'd7; b_arr[0] = 18'd9;
        advance(1);
        total++; if (res_valid !== 1'b1 || res_product !== 36'd63) begin
            bad++; $display("FAIL drain_pending: got v=%0b p=%0d expected v=1 p=63", res_valid, res_product);
        end
        load_req(0);
        cfg_en = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL drain_ready_bp: got %b expected 0000", req_ready); end
        advance(0);
        total++; if (busy !== 1'b1 || res_valid !== 1'b1 || res_product !== 36'd63) begin
            bad++; $display("FAIL drain_state: got busy=%0b v=%0b p=%0d expected busy=1 v=1 p=63", busy, res_valid, res_product);
        end
        res_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL drain_no_grant: got %b expected 0000", req_ready); end
        advance(0);
        total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL drain_idle: got busy=%0b v=%0b expected busy=0 v=0", busy, res_valid);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        cfg_en = 1'b1;
        res_ready = 1'b0;
        advance(0);
        load_req(1);
        load_req(3);
        advance(1);
        total++; if (res_valid !== 1'b1 || res_id !== 2'd1) begin
            bad++; $display("FAIL rmid_pending: got v=%0b id=%0d expected v=1 id=1", res_valid, res_id);
        end
        load_req(1);
        ap_rst = 1'b1;
        advance(0);
        total++; if (res_valid !== 1'b0 || res_id !== '0 || res_product !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL rmid_reset: got v=%0b id=%0d p=%0h busy=%0b expected all 0", res_valid, res_id, res_product, busy);
        end
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_ready: got %b expected 0000", req_ready); end
        ap_rst = 1'b0;
        advance(0);
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rmid_first: got %b expected 0010", req_ready); end
        advance(1);
        total++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_product !== m_prod) begin
            bad++; $display("FAIL rmid_result: got v=%0b id=%0d p=%0h expected v=1 id=1 p=%0h", res_valid, res_id, res_product, m_prod);
        end
    endtask

    task automatic test_random();
        do_reset();
        cfg_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) cfg_en = ~cfg_en;
            res_ready = ($urandom_range(0, 3) != 0);
            ap_rst    = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) load_req(i);
            end
            #1;
            total++; if (req_ready !== model_ready()) begin
                bad++; $display("FAIL rand_ready c%0d: got %b expected %b", c, req_ready, model_ready());
            end
            advance(1);
            total++; if (res_valid !== m_valid || busy !== (m_state != 0)) begin
                bad++; $display("FAIL rand_ctrl c%0d: got v=%0b busy=%0b expected v=%0b busy=%0b", c, res_valid, busy, m_valid, (m_state != 0));
            end
            if (m_valid) begin
                total++; if (res_id !== IW'(m_id) || res_product !== m_prod) begin
                    bad++; $display("FAIL rand_data c%0d: got id=%0d p=%0h expected id=%0d p=%0h", c, res_id, res_product, m_id, m_prod);
                end
            end
        end
        ap_rst = 1'b0;
    endtask

    initial begin
        ap_rst    = 1'b1;
        cfg_en    = 1'b0;
        res_ready = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        m_state = 0; m_ptr = 0; m_id = 0; m_valid = 0; m_prod = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_boundary();
        test_drain();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
